// File: rtl/rv32i_rf_pkg.sv
// Shared constants and types for the rv32i register file with scoreboard.
package rv32i_rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef logic [4:0] reg_addr_t;

  typedef enum logic [4:0] {
    ZERO, RA, SP, GP, TP, T0, T1, T2,
    S0, S1, A0, A1, A2, A3, A4, A5,
    A6, A7, S2, S3, S4, S5, S6, S7,
    S8, S9, S10, S11, T3, T4, T5, T6
  } reg_abi_e;

endpackage

// File: rtl/rv32i_rf_read_port.sv
// One asynchronous read port: address mux, x0 forcing and, when RF_BYPASS_EN
// is defined, same-cycle writeback forwarding.
module rv32i_rf_read_port
  import rv32i_rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  regs [NREGS],
  input  logic [NREGS-1:0] busy_vec,
`ifdef RF_BYPASS_EN
  input  logic             wb_act,
  input  logic [AW-1:0]    wb_reg,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             iss_set,
  input  logic [AW-1:0]    iss_reg,
`endif
  output logic [XLEN-1:0]  rd_data,
  output logic             rd_busy
);

  always_comb begin
    rd_data = regs[addr];
    rd_busy = busy_vec[addr];
`ifdef RF_BYPASS_EN
    // A same-cycle issue to the forwarded register keeps it pending.
    if (wb_act && (wb_reg == addr)) begin
      rd_data = wb_data;
      rd_busy = iss_set && (iss_reg == addr);
    end
`endif
    if (addr == '0) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/rv32i_regfile_sb.sv
// Multi-read-port integer register file with an integrated pending-write
// scoreboard. Optional same-cycle read bypass under macro RF_BYPASS_EN.
module rv32i_regfile_sb
  import rv32i_rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wb_enable,
  input  logic [AW-1:0]     wb_reg,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_reg,
  output logic              iss_ready,
  output logic [NREGS-1:0]  busy_vec,
  output logic [CW-1:0]     busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    busy_cnt_q, busy_cnt_d;
  logic             wb_act, iss_set, cnt_inc, cnt_dec;

  always_comb begin
    iss_ready = (iss_reg == '0) || !busy_q[iss_reg] || (wb_enable && (wb_reg == iss_reg));
    wb_act    = wb_enable && (wb_reg != '0);
    iss_set   = iss_valid && iss_ready && (iss_reg != '0);

    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_act) begin
      regs_d[wb_reg] = wb_data;
      busy_d[wb_reg] = 1'b0;
    end
    // Issue is applied after writeback so it wins the busy bit.
    if (iss_set) busy_d[iss_reg] = 1'b1;

    cnt_inc    = iss_set && !busy_q[iss_reg];
    cnt_dec    = wb_act && busy_q[wb_reg] && !(iss_set && (iss_reg == wb_reg));
    busy_cnt_d = busy_cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q     <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = busy_cnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rv32i_rf_read_port #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_port (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (regs_q),
      .busy_vec(busy_q),
`ifdef RF_BYPASS_EN
      .wb_act  (wb_act),
      .wb_reg  (wb_reg),
      .wb_data (wb_data),
      .iss_set (iss_set),
      .iss_reg (iss_reg),
`endif
      .rd_data (rd_data[k*XLEN +: XLEN]),
      .rd_busy (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Self-checking bench for rv32i_regfile_sb: directed steps then random traffic
// against an array-based reference model.
module tb_rv32i_regfile_sb;
  import rv32i_rf_pkg::*;

  localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5, CW = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              wb_enable;
  logic [AW-1:0]     wb_reg;
  logic [XLEN-1:0]   wb_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_reg;
  logic              iss_ready;
  logic [NREGS-1:0]  busy_vec;
  logic [CW-1:0]     busy_cnt;

  rv32i_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg), .iss_ready(iss_ready),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  logic [XLEN-1:0] m_mem [NREGS];
  bit              m_busy [NREGS];
  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return (iss_reg == 0) || !m_busy[iss_reg] || (wb_enable && wb_reg == iss_reg);
  endfunction

  function automatic logic [XLEN-1:0] m_rdata(input int a);
    if (a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wb_enable && wb_reg != 0 && int'(wb_reg) == a) return wb_data;
`endif
    return m_mem[a];
  endfunction

  function automatic bit m_rbusy(input int a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if (wb_enable && wb_reg != 0 && int'(wb_reg) == a)
      return iss_valid && m_ready() && int'(iss_reg) == a;
`endif
    return m_busy[a];
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [NREGS-1:0] m_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".iss_ready"}, 64'(iss_ready), 64'(m_ready()));
    check({tag, ".busy_vec"}, 64'(busy_vec), 64'(m_vec()));
    check({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(m_count()));
    for (int k = 0; k < NRD; k++) begin
      check($sformatf("%s.rd_data%0d", tag, k), 64'(rd_data[k*XLEN +: XLEN]),
            64'(m_rdata(int'(rd_addr[k*AW +: AW]))));
      check($sformatf("%s.rd_busy%0d", tag, k), 64'(rd_busy[k]),
            64'(m_rbusy(int'(rd_addr[k*AW +: AW]))));
    end
  endtask

  // Apply one clock edge to both DUT and model, then settle 1 time unit.
  task automatic tick();
    bit acc;
    acc = iss_valid && m_ready();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin m_mem[i] = '0; m_busy[i] = 0; end
    end else begin
      if (wb_enable && wb_reg != 0) begin m_mem[wb_reg] = wb_data; m_busy[wb_reg] = 0; end
      if (acc && iss_reg != 0) m_busy[iss_reg] = 1;
    end
    #1;
  endtask

  task automatic set_ports(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) begin m_mem[i] = 'x; m_busy[i] = 0; end
    reset = 1; wb_enable = 0; wb_reg = 0; wb_data = 0; iss_valid = 0; iss_reg = 0;
    rd_addr = '0;
    #2;
    tick();
    reset = 0;
    #1;
    check("rst.iss_ready", 64'(iss_ready), 64'(1));
    check("rst.busy_cnt", 64'(busy_cnt), 64'(0));
    check("rst.busy_vec", 64'(busy_vec), 64'(0));
    for (int a = 1; a < NREGS; a++) begin
      set_ports(a, NREGS - a);
      #1;
      check($sformatf("rst.rd_data0.x%0d", a), 64'(rd_data[XLEN-1:0]), 64'(0));
      check($sformatf("rst.rd_busy.x%0d", a), 64'(rd_busy), 64'(0));
    end

    // Issue x5, then write it back.
    iss_valid = 1; iss_reg = AW'(T0);
    tick();
    iss_valid = 0; set_ports(5, 0); #1;
    check("iss5.rd_busy0", 64'(rd_busy[0]), 64'(1));
    check("iss5.busy_vec5", 64'(busy_vec[5]), 64'(1));
    check("iss5.busy_cnt", 64'(busy_cnt), 64'(1));
    wb_enable = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
    tick();
    wb_enable = 0; #1;
    check("wb5.rd_data0", 64'(rd_data[XLEN-1:0]), 64'h0DEADBEEF);
    check("wb5.rd_busy0", 64'(rd_busy[0]), 64'(0));
    check("wb5.busy_cnt", 64'(busy_cnt), 64'(0));

    // WAW stall, then issue together with writeback to the same register.
    iss_valid = 1; iss_reg = 5;
    tick();
    #1;
    check("waw.iss_ready", 64'(iss_ready), 64'(0));
    tick();
    check("waw.busy_cnt", 64'(busy_cnt), 64'(1));
    wb_enable = 1; wb_reg = 5; wb_data = 32'hCAFEF00D; #1;
    check("iss_wb.iss_ready", 64'(iss_ready), 64'(1));
    check_all("iss_wb.pre");
    tick();
    iss_valid = 0; wb_enable = 0; #1;
    check("iss_wb.rd_data0", 64'(rd_data[XLEN-1:0]), 64'hCAFEF00D);
    check("iss_wb.rd_busy0", 64'(rd_busy[0]), 64'(1));
    check("iss_wb.busy_cnt", 64'(busy_cnt), 64'(1));
    wb_enable = 1; wb_reg = 5; wb_data = 32'h5;
    tick();

    // Register 0 is immutable and never busy.
    wb_enable = 1; wb_reg = 0; wb_data = 32'hFFFFFFFF; iss_valid = 1; iss_reg = 0;
    set_ports(0, 0); #1;
    check("x0.iss_ready", 64'(iss_ready), 64'(1));
    tick();
    wb_enable = 0; iss_valid = 0; #1;
    check("x0.rd_data0", 64'(rd_data[XLEN-1:0]), 64'(0));
    check("x0.busy_vec0", 64'(busy_vec[0]), 64'(0));
    check("x0.busy_cnt", 64'(busy_cnt), 64'(0));

    // Read-during-write on port 1.
    set_ports(0, 7); wb_enable = 1; wb_reg = 7; wb_data = 32'h12345678; #1;
`ifdef RF_BYPASS_EN
    check("byp.same_cycle", 64'(rd_data[2*XLEN-1:XLEN]), 64'h12345678);
`else
    check("byp.same_cycle", 64'(rd_data[2*XLEN-1:XLEN]), 64'(0));
`endif
    tick();
    wb_enable = 0; #1;
    check("byp.next_cycle", 64'(rd_data[2*XLEN-1:XLEN]), 64'h12345678);

    // Reset mid-operation discards the same-cycle writeback.
    iss_valid = 1;
    for (int r = 1; r <= 4; r++) begin iss_reg = AW'(r); tick(); end
    iss_valid = 0; #1;
    check("pre_rst.busy_cnt", 64'(busy_cnt), 64'(4));
    reset = 1; wb_enable = 1; wb_reg = 2; wb_data = 32'hA5A5A5A5;
    tick();
    reset = 0; wb_enable = 0;
    set_ports(2, 7); #1;
    check("mid_rst.busy_vec", 64'(busy_vec), 64'(0));
    check("mid_rst.busy_cnt", 64'(busy_cnt), 64'(0));
    check("mid_rst.rd_data", 64'(rd_data), 64'(0));
    check("mid_rst.iss_ready", 64'(iss_ready), 64'(1));

    // Random issue/writeback traffic.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      iss_valid = $urandom_range(0, 1);
      iss_reg   = AW'($urandom_range(0, 7));
      wb_enable = $urandom_range(0, 1);
      wb_reg    = ($urandom_range(0, 3) == 0) ? iss_reg : AW'($urandom_range(0, 7));
      wb_data   = $urandom;
      set_ports($urandom_range(0, 7), ($urandom_range(0, 1) == 1) ? int'(wb_reg) : $urandom_range(0, 31));
      #1;
      check_all($sformatf("rnd%0d", c));
      tick();
    end
    reset = 0; wb_enable = 0; iss_valid = 0; #1;
    check_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
